touch_gesture_ctrl: RTL and testbench
=====================================

# touch_gesture_ctrl

Controller that sequences the two capacitive touch pads into a qualified two-hand hold gesture. It synchronizes and debounces both raw pad inputs and requires the second pad to join within a pairing window. It then requires both pads held for a hold time before issuing a one-cycle confirm pulse. It sits between the pad pins and the main game FSM, replacing the raw AND of the two pads.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles before a debounced pad changes.
- PAIR_WINDOW, 5000: max cycles from first pad press to second pad press.
- HOLD_CYCLES, 50000: cycles both pads must stay down before confirm.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- touch1  in  1  raw pad 1, asynchronous to clk
- touch2  in  1  raw pad 2, asynchronous to clk
- touched  out  1  level: both debounced pads currently down
- confirm  out  1  one-cycle pulse: hold gesture completed
- abort  out  1  one-cycle pulse: gesture abandoned
- state  out  2  current FSM state encoding (debug)

## Operation
- Each pad: 2-flop synchronizer, then debounce counter. The debounced value flips only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
- touched = d1 & d2, registered.
- FSM states and encodings:
  - IDLE=0
    - exactly one pad down -> ARMED
    - both go down on the same cycle -> HOLDING
  - ARMED=1: window counter runs.
    - second pad down -> HOLDING
    - first pad released before that -> IDLE, with abort
    - counter reaches PAIR_WINDOW-1 with only one pad down -> LOCKOUT, with abort
  - HOLDING=2: hold counter runs.
    - either pad released -> IDLE, with abort
    - counter reaches HOLD_CYCLES-1 with both still down -> LOCKOUT, with confirm
  - LOCKOUT=3: no events. Both pads released -> IDLE.
- Counters clear on state entry and increment once per cycle in their state. Widths are $clog2(param+1) and never wrap, because the state exits at the terminal count.
- Simultaneous release and terminal count in HOLDING: release wins, giving abort and no confirm.
- Simultaneous second press and window expiry in ARMED: press wins, giving HOLDING.
- confirm and abort are never high in the same cycle.

## Timing
- Reset (rst low, asynchronous) forces:
  - state=IDLE, all counters 0, synchronizer and debounced values 0
  - touched=0, confirm=0, abort=0
- Reset mid-gesture discards all progress. After release the FSM starts from IDLE with no pulse.
- Raw-to-debounced latency: 2 sync cycles + DEBOUNCE_CYCLES.
- touched lags the debounced values by 1 cycle.
- confirm/abort are registered. They are high during the first cycle of the destination state, for exactly one cycle.
- Confirm occurs HOLD_CYCLES cycles after entering HOLDING.

## Configuration
- TOUCH_GESTURE_ABORT_CNT_EN defined:
  - adds output abort_cnt [7:0], a saturating count of abort pulses since reset (stops at 255, reset value 0).
- Macro undefined:
  - port and logic are absent.
  - all other behaviour is identical.

## Structure
- Package touch_pkg holds:
  - the 2-bit state typedef with IDLE/ARMED/HOLDING/LOCKOUT encodings
  - the abort counter width constant
- Sub-module touch_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, clean) is instantiated once per pad.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, PAIR_WINDOW=10, HOLD_CYCLES=20.
- Both pads pressed together and held for 40 cycles -> touched rises 7 cycles after the press. confirm pulses once, 20 cycles after HOLDING entry. state goes to 3, then to 0 after release.
- touch1 pressed, touch2 never pressed -> abort pulses 10 cycles after ARMED entry. State is LOCKOUT until touch1 is released, then IDLE. No confirm.
- touch1 pressed, touch2 pressed 5 cycles later, touch2 released after 12 cycles in HOLDING -> abort pulses, state returns to IDLE, no confirm.
- Glitch on touch1 of 3 cycles high -> debounced value unchanged, state stays IDLE, no pulses.
- rst asserted during HOLDING at hold count 15 -> all outputs 0 immediately. After release with pads still held, debounce restarts and a fresh full hold is required for confirm.
- With TOUCH_GESTURE_ABORT_CNT_EN: drive 300 aborts -> abort_cnt saturates at 255.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types for the two-pad hold gesture controller.
// Holds the FSM state encoding and the abort counter width.
package touch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDING = 2'd2,
    LOCKOUT = 2'd3
  } gesture_state_e;

  localparam int ABORT_CNT_W = 8;

endpackage

// File: rtl/touch_debounce.sv
// Pad conditioner: 2-flop synchronizer followed by a consecutive-cycle debounce counter.
// Latency: 2 + DEBOUNCE_CYCLES cycles from raw change to clean change; no backpressure.
module touch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          clean_q;
  logic          clean_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only advances while the synchronized input disagrees with clean.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == TERM) begin
        clean_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/touch_gesture_ctrl.sv
// Two-pad hold gesture qualifier: debounce, pairing window, hold timer, confirm/abort pulses.
// Latency: confirm HOLD_CYCLES after HOLDING entry; pulses registered; no backpressure.
// TOUCH_GESTURE_ABORT_CNT_EN adds a saturating abort_cnt output.
module touch_gesture_ctrl
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PAIR_WINDOW     = 5000,
  parameter int HOLD_CYCLES     = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch1,
  input  logic       touch2,
  output logic       touched,
  output logic       confirm,
  output logic       abort,
  output logic [1:0] state
`ifdef TOUCH_GESTURE_ABORT_CNT_EN
  ,
  output logic [ABORT_CNT_W-1:0] abort_cnt
`endif
);

  localparam int WW = $clog2(PAIR_WINDOW + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [WW-1:0] WIN_TERM  = WW'(PAIR_WINDOW - 1);
  localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES - 1);

  logic d1;
  logic d2;

  touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch1),
    .clean (d1)
  );

  touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (touch2),
    .clean (d2)
  );

  gesture_state_e state_q;
  gesture_state_e state_d;
  logic [WW-1:0]  win_cnt_q;
  logic [WW-1:0]  win_cnt_d;
  logic [HW-1:0]  hold_cnt_q;
  logic [HW-1:0]  hold_cnt_d;
  logic           first_q;
  logic           first_d;
  logic           touched_q;
  logic           touched_d;
  logic           confirm_q;
  logic           confirm_d;
  logic           abort_q;
  logic           abort_d;
  logic           first_down;

  // first_q remembers which pad armed the gesture (0 = pad 1, 1 = pad 2).
  assign first_down = first_q ? d2 : d1;
  assign touched_d  = d1 & d2;

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = '0;
    hold_cnt_d = '0;
    first_d    = first_q;
    confirm_d  = 1'b0;
    abort_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d1 && d2) begin
          state_d = HOLDING;
        end else if (d1 ^ d2) begin
          state_d = ARMED;
          first_d = d2;
        end
      end
      ARMED: begin
        // A late second press beats window expiry on the same cycle.
        if (d1 && d2) begin
          state_d = HOLDING;
        end else if (!first_down) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (win_cnt_q == WIN_TERM) begin
          state_d = LOCKOUT;
          abort_d = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q + WW'(1);
        end
      end
      HOLDING: begin
        // A release beats hold completion on the same cycle.
        if (!(d1 && d2)) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (hold_cnt_q == HOLD_TERM) begin
          state_d   = LOCKOUT;
          confirm_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      LOCKOUT: begin
        if (!d1 && !d2) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TOUCH_GESTURE_ABORT_CNT_EN
  logic [ABORT_CNT_W-1:0] abort_cnt_q;
  logic [ABORT_CNT_W-1:0] abort_cnt_d;

  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (abort_d && (abort_cnt_q != {ABORT_CNT_W{1'b1}})) begin
      abort_cnt_d = abort_cnt_q + ABORT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_cnt_q <= '0;
    end else begin
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign abort_cnt = abort_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      hold_cnt_q <= '0;
      first_q    <= 1'b0;
      touched_q  <= 1'b0;
      confirm_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      first_q    <= first_d;
      touched_q  <= touched_d;
      confirm_q  <= confirm_d;
      abort_q    <= abort_d;
    end
  end

  assign touched = touched_q;
  assign confirm = confirm_q;
  assign abort   = abort_q;
  assign state   = state_q;

endmodule

// File: tb/tb_touch_gesture_ctrl.sv
// Directed bench for touch_gesture_ctrl with DEBOUNCE_CYCLES=4, PAIR_WINDOW=10, HOLD_CYCLES=20.
// Define TOUCH_GESTURE_ABORT_CNT_EN to also exercise the abort counter.
module tb_touch_gesture_ctrl;

  logic       clk;
  logic       rst;
  logic       touch1;
  logic       touch2;
  logic       touched;
  logic       confirm;
  logic       abort;
  logic [1:0] state;
`ifdef TOUCH_GESTURE_ABORT_CNT_EN
  logic [7:0] abort_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  touch_gesture_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .PAIR_WINDOW     (10),
    .HOLD_CYCLES     (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .touch1    (touch1),
    .touch2    (touch2),
    .touched   (touched),
    .confirm   (confirm),
    .abort     (abort),
    .state     (state)
`ifdef TOUCH_GESTURE_ABORT_CNT_EN
    ,
    .abort_cnt (abort_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After step() returns, outputs reflect the most recent rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    touch1 = 1'b0;
    touch2 = 1'b0;
    step();
    step();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d exp 0", state);
    end
    n_checks++;
    if (touched !== 1'b0 || confirm !== 1'b0 || abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got touched=%b confirm=%b abort=%b exp 000", touched, confirm, abort);
    end
`ifdef TOUCH_GESTURE_ABORT_CNT_EN
    n_checks++;
    if (abort_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_abort_cnt got %0d exp 0", abort_cnt);
    end
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_both_hold();
    logic [1:0] exp_s;
    logic       exp_t;
    touch1 = 1'b1;
    touch2 = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      step();
      exp_t = (k >= 7 && k < 47);
      exp_s = (k < 7) ? 2'd0 : (k < 27) ? 2'd2 : (k < 47) ? 2'd3 : 2'd0;
      n_checks++;
      if (state !== exp_s) begin
        n_fail++;
        $display("FAIL both_hold state k=%0d got %0d exp %0d", k, state, exp_s);
      end
      n_checks++;
      if (touched !== exp_t) begin
        n_fail++;
        $display("FAIL both_hold touched k=%0d got %b exp %b", k, touched, exp_t);
      end
      n_checks++;
      if (confirm !== (k == 27) || abort !== 1'b0) begin
        n_fail++;
        $display("FAIL both_hold pulses k=%0d got confirm=%b abort=%b exp confirm=%b abort=0",
                 k, confirm, abort, (k == 27));
      end
      if (k == 40) begin
        touch1 = 1'b0;
        touch2 = 1'b0;
      end
    end
  endtask

  task automatic test_armed_timeout();
    logic [1:0] exp_s;
    touch1 = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp_s = (k < 7) ? 2'd0 : (k < 17) ? 2'd1 : (k < 32) ? 2'd3 : 2'd0;
      n_checks++;
      if (state !== exp_s) begin
        n_fail++;
        $display("FAIL armed_timeout state k=%0d got %0d exp %0d", k, state, exp_s);
      end
      n_checks++;
      if (abort !== (k == 17) || confirm !== 1'b0) begin
        n_fail++;
        $display("FAIL armed_timeout pulses k=%0d got abort=%b confirm=%b exp abort=%b confirm=0",
                 k, abort, confirm, (k == 17));
      end
      if (k == 25) touch1 = 1'b0;
    end
  endtask

  task automatic test_pair_release();
    logic [1:0] exp_s;
    logic       exp_t;
    touch1 = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      step();
      exp_s = (k < 7) ? 2'd0 : (k < 12) ? 2'd1 : (k < 31) ? 2'd2 : 2'd0;
      exp_t = (k >= 12 && k <= 30);
      n_checks++;
      if (state !== exp_s) begin
        n_fail++;
        $display("FAIL pair_release state k=%0d got %0d exp %0d", k, state, exp_s);
      end
      n_checks++;
      if (touched !== exp_t) begin
        n_fail++;
        $display("FAIL pair_release touched k=%0d got %b exp %b", k, touched, exp_t);
      end
      n_checks++;
      if (abort !== (k == 31) || confirm !== 1'b0) begin
        n_fail++;
        $display("FAIL pair_release pulses k=%0d got abort=%b confirm=%b exp abort=%b confirm=0",
                 k, abort, confirm, (k == 31));
      end
      if (k == 5)  touch2 = 1'b1;
      if (k == 24) touch2 = 1'b0;
    end
    touch1 = 1'b0;
    rst    = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_glitch();
    touch1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (state !== 2'd0 || touched !== 1'b0 || confirm !== 1'b0 || abort !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch k=%0d got state=%0d touched=%b confirm=%b abort=%b exp all 0",
                 k, state, touched, confirm, abort);
      end
      if (k == 3) touch1 = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_s;
    touch1 = 1'b1;
    touch2 = 1'b1;
    for (int k = 1; k <= 22; k++) step();
    n_checks++;
    if (state !== 2'd2 || touched !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre got state=%0d touched=%b exp state=2 touched=1", state, touched);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'd0 || touched !== 1'b0 || confirm !== 1'b0 || abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid async got state=%0d touched=%b confirm=%b abort=%b exp all 0",
               state, touched, confirm, abort);
    end
    step();
    step();
    step();
    rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_s = (k < 7) ? 2'd0 : (k < 27) ? 2'd2 : 2'd3;
      n_checks++;
      if (state !== exp_s) begin
        n_fail++;
        $display("FAIL reset_mid state k=%0d got %0d exp %0d", k, state, exp_s);
      end
      n_checks++;
      if (confirm !== (k == 27) || abort !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid pulses k=%0d got confirm=%b abort=%b exp confirm=%b abort=0",
                 k, confirm, abort, (k == 27));
      end
    end
    touch1 = 1'b0;
    touch2 = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid release got state=%0d exp 0", state);
    end
  endtask

`ifdef TOUCH_GESTURE_ABORT_CNT_EN
  task automatic test_abort_sat();
    int pulses;
    pulses = 0;
    n_checks++;
    if (abort_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_sat start got %0d exp 0", abort_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      touch1 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
        step();
        if (abort === 1'b1) pulses++;
        if (k == 7) touch1 = 1'b0;
      end
      if (i == 0) begin
        n_checks++;
        if (abort_cnt !== 8'd1) begin
          n_fail++;
          $display("FAIL abort_sat first got %0d exp 1", abort_cnt);
        end
      end
      if (i == 254) begin
        n_checks++;
        if (abort_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL abort_sat at255 got %0d exp 255", abort_cnt);
        end
      end
    end
    n_checks++;
    if (pulses != 300) begin
      n_fail++;
      $display("FAIL abort_sat pulses got %0d exp 300", pulses);
    end
    n_checks++;
    if (abort_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL abort_sat final got %0d exp 255", abort_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_both_hold();
    test_armed_timeout();
    test_pair_release();
    test_glitch();
    test_reset_mid();
`ifdef TOUCH_GESTURE_ABORT_CNT_EN
    test_abort_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
